dual_port_ram: RTL and testbench
================================

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 6, address width; depth SHALL be 2**ADDR_WIDTH (64 words).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 Port list (name direction width meaning):
- clk  input  1  sole clock; all storage and outputs update on its rising edge
- rst  input  1  asynchronous active-high reset
- data_a  input  DATA_WIDTH  port A write data
- addr_a  input  ADDR_WIDTH  port A address
- we_a  input  1  port A write enable (1 = write, 0 = read)
- data_b  input  DATA_WIDTH  port B write data
- addr_b  input  ADDR_WIDTH  port B address
- we_b  input  1  port B write enable
- q_a  output  DATA_WIDTH  port A registered read data
- q_b  output  DATA_WIDTH  port B registered read data
REQ-005 Positional port declaration order SHALL be data_a, addr_a, we_a, data_b, addr_b, we_b, clk, q_a, q_b, rst, so that existing positional instantiations stay valid.

Function
REQ-006 Storage SHALL be a true dual-port array of 2**ADDR_WIDTH words of DATA_WIDTH bits, both ports fully independent and synchronous to clk.
REQ-007 Port A write: on a rising edge with we_a=1, mem[addr_a] <= data_a, and q_a <= data_a (write-through) in the same edge.
REQ-008 Port A read: on a rising edge with we_a=0, q_a <= mem[addr_a]; read latency is 1 clock; mem is unchanged.
REQ-009 Port B SHALL behave identically to REQ-007/REQ-008 using data_b, addr_b, we_b and q_b.
REQ-010 q_a and q_b SHALL hold their value between rising edges; input changes between edges have no effect.
REQ-011 Cross-port read/write collision (one port writes, the other reads the same address on the same edge): the reading port SHALL return the old (pre-write) contents; the new data is visible from the next edge.
REQ-012 Write/write collision (both we=1, addr_a==addr_b): port A data SHALL be stored; q_a = data_a, q_b = data_b (each port's own write-through).
REQ-013 Both ports reading the same address SHALL both return the stored word.
REQ-014 Address range is the full ADDR_WIDTH space; there is no out-of-range condition and no address wrap beyond the modulo of the width.
REQ-015 Memory contents after power-up are undefined until written.

Reset
REQ-016 While rst=1, q_a and q_b SHALL be forced to 0 immediately (asynchronously, without waiting for clk) and held at 0.
REQ-017 While rst=1, writes SHALL be blocked.
REQ-018 Memory contents SHALL NOT be cleared by reset.
REQ-019 After rst deasserts, the first rising edge SHALL perform normal read/write operation.
REQ-020 Reset asserted mid-operation SHALL abort any write on that edge; words written before reset SHALL remain readable after reset.

Verification
REQ-021 Simultaneous writes: we_a=1, addr_a=0x01, data_a=0x33; we_b=1, addr_b=0x02, data_b=0x44; one edge -> q_a=0x33, q_b=0x44.
REQ-022 Write A / read B: next edge we_a=1, addr_a=0x03, data_a=0x55; we_b=0, addr_b=0x01 -> q_a=0x55, q_b=0x33.
REQ-023 Dual read: next edge we_a=0, addr_a=0x02; we_b=0, addr_b=0x03 -> q_a=0x44, q_b=0x55.
REQ-024 Read A / write B: next edge we_a=0, addr_a=0x01; we_b=1, addr_b=0x02, data_b=0x77 -> q_a=0x33, q_b=0x77; a following read of 0x02 on A returns 0x77.
REQ-025 Collisions: A writes 0xAA to 0x10 while B reads 0x10 -> q_b = old value, next-edge read = 0xAA; both ports write 0x20 (A=0x11, B=0x22) -> later read of 0x20 returns 0x11.
REQ-026 Reset: assert rst between edges -> q_a=q_b=0 at once with no clk edge; deassert, read 0x01 -> 0x33 (contents retained).

Source files
------------

// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM with registered, write-through read ports.
// Port A wins a write/write collision; cross-port reads return pre-write data.
module dual_port_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  we_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  we_b,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  input  logic                  rst
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] q_a_d, q_a_q;
  logic [DATA_WIDTH-1:0] q_b_d, q_b_q;

  // Storage is never reset; port A is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we_b) mem_q[addr_b] <= data_b;
      if (we_a) mem_q[addr_a] <= data_a;
    end
  end

  always_comb begin
    q_a_d = we_a ? data_a : mem_q[addr_a];
    q_b_d = we_b ? data_b : mem_q[addr_b];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram with hand-computed expectations.
module tb_dual_port_ram;

  logic [7:0] data_a, data_b;
  logic [5:0] addr_a, addr_b;
  logic       we_a, we_b;
  logic       clk, rst;
  logic [7:0] q_a, q_b;

  int n_checks = 0;
  int n_pass   = 0;

  dual_port_ram #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(6)
  ) u_dut (
    .data_a(data_a),
    .addr_a(addr_a),
    .we_a  (we_a),
    .data_b(data_b),
    .addr_b(addr_b),
    .we_b  (we_b),
    .clk   (clk),
    .q_a   (q_a),
    .q_b   (q_b),
    .rst   (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Apply one set of port inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic wa, input logic [5:0] aa, input logic [7:0] da,
                      input logic wb, input logic [5:0] ab, input logic [7:0] db);
    we_a = wa; addr_a = aa; data_a = da;
    we_b = wb; addr_b = ab; data_b = db;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    we_a = 1'b0; addr_a = '0; data_a = '0;
    we_b = 1'b0; addr_b = '0; data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q_a", q_a, 8'h00);
    check("reset_q_b", q_b, 8'h00);
    rst = 1'b0;

    step(1'b1, 6'h01, 8'h33, 1'b1, 6'h02, 8'h44);
    check("simul_wr_q_a", q_a, 8'h33);
    check("simul_wr_q_b", q_b, 8'h44);

    step(1'b1, 6'h03, 8'h55, 1'b0, 6'h01, 8'h00);
    check("wrA_rdB_q_a", q_a, 8'h55);
    check("wrA_rdB_q_b", q_b, 8'h33);

    step(1'b0, 6'h02, 8'h00, 1'b0, 6'h03, 8'h00);
    check("dual_rd_q_a", q_a, 8'h44);
    check("dual_rd_q_b", q_b, 8'h55);

    step(1'b0, 6'h01, 8'h00, 1'b1, 6'h02, 8'h77);
    check("rdA_wrB_q_a", q_a, 8'h33);
    check("rdA_wrB_q_b", q_b, 8'h77);
    step(1'b0, 6'h02, 8'h00, 1'b0, 6'h01, 8'h00);
    check("rdA_after_wrB", q_a, 8'h77);
    check("rdB_0x01", q_b, 8'h33);

    // Inputs changing between edges must not disturb the outputs.
    we_a = 1'b1; addr_a = 6'h05; data_a = 8'hE1;
    we_b = 1'b1; addr_b = 6'h06; data_b = 8'hE2;
    #3;
    check("hold_q_a", q_a, 8'h77);
    check("hold_q_b", q_b, 8'h33);

    // Read/write collision: B sees the old word, new word visible next edge.
    step(1'b1, 6'h10, 8'h0F, 1'b0, 6'h00, 8'h00);
    step(1'b1, 6'h10, 8'hAA, 1'b0, 6'h10, 8'h00);
    check("rw_coll_q_a", q_a, 8'hAA);
    check("rw_coll_q_b_old", q_b, 8'h0F);
    step(1'b0, 6'h10, 8'h00, 1'b0, 6'h10, 8'h00);
    check("rw_coll_next_a", q_a, 8'hAA);
    check("rw_coll_next_b", q_b, 8'hAA);

    // Write/write collision: each port echoes its own data, A's data is stored.
    step(1'b1, 6'h20, 8'h11, 1'b1, 6'h20, 8'h22);
    check("ww_coll_q_a", q_a, 8'h11);
    check("ww_coll_q_b", q_b, 8'h22);
    step(1'b0, 6'h20, 8'h00, 1'b0, 6'h20, 8'h00);
    check("ww_coll_rd_a", q_a, 8'h11);
    check("ww_coll_rd_b", q_b, 8'h11);

    // Address space extremes.
    step(1'b1, 6'h3F, 8'hC3, 1'b1, 6'h00, 8'h3C);
    step(1'b0, 6'h00, 8'h00, 1'b0, 6'h3F, 8'h00);
    check("addr_min_rd", q_a, 8'h3C);
    check("addr_max_rd", q_b, 8'hC3);

    // Reset mid-operation: async clear, writes blocked, contents retained.
    step(1'b1, 6'h30, 8'h5A, 1'b0, 6'h01, 8'h00);
    check("pre_rst_q_a", q_a, 8'h5A);
    check("pre_rst_q_b", q_b, 8'h33);
    rst = 1'b1;
    #1;
    check("async_rst_q_a", q_a, 8'h00);
    check("async_rst_q_b", q_b, 8'h00);
    step(1'b1, 6'h30, 8'hFF, 1'b1, 6'h01, 8'hEE);
    check("rst_hold_q_a", q_a, 8'h00);
    check("rst_hold_q_b", q_b, 8'h00);
    rst = 1'b0;
    #1;
    step(1'b0, 6'h30, 8'h00, 1'b0, 6'h01, 8'h00);
    check("post_rst_rd_0x30", q_a, 8'h5A);
    check("post_rst_rd_0x01", q_b, 8'h33);
    step(1'b1, 6'h04, 8'h9C, 1'b0, 6'h02, 8'h00);
    check("post_rst_wr_q_a", q_a, 8'h9C);
    check("post_rst_rd_0x02", q_b, 8'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
